vga_pattern_gen: RTL and testbench

//  Parametrised test-pattern source between the vga timing generator and vga2dvid, in the clk_pixel domain.

---
 rtl/vga_pattern_gen_pkg.sv | 47 ++++
 rtl/vga_pattern_gen_cursor.sv | 110 +++++++++++
 rtl/vga_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA test-pattern source: mode encodings,
// palette indices and the palette lookup used by the pattern mux.
package vga_pattern_gen_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID    = 3'd0,
        MODE_VBARS    = 3'd1,
        MODE_HBANDS   = 3'd2,
        MODE_CHECKER  = 3'd3,
        MODE_GRADIENT = 3'd4,
        MODE_ALT      = 3'd5,
        MODE_RSVD6    = 3'd6,
        MODE_RSVD7    = 3'd7
    } mode_e;

    localparam logic [2:0] PAL_BLACK   = 3'd0;
    localparam logic [2:0] PAL_RED     = 3'd1;
    localparam logic [2:0] PAL_GREEN   = 3'd2;
    localparam logic [2:0] PAL_BLUE    = 3'd3;
    localparam logic [2:0] PAL_YELLOW  = 3'd4;
    localparam logic [2:0] PAL_CYAN    = 3'd5;
    localparam logic [2:0] PAL_MAGENTA = 3'd6;
    localparam logic [2:0] PAL_WHITE   = 3'd7;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    function automatic rgb_t palette(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            PAL_BLACK:   c = 24'h000000;
            PAL_RED:     c = 24'hFF0000;
            PAL_GREEN:   c = 24'h00FF00;
            PAL_BLUE:    c = 24'h0000FF;
            PAL_YELLOW:  c = 24'hFFFF00;
            PAL_CYAN:    c = 24'h00FFFF;
            PAL_MAGENTA: c = 24'hFF00FF;
            PAL_WHITE:   c = 24'hFFFFFF;
            default:     c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_cursor.sv
// Pixel-position tracker: frame-start detect, x/y counters, bar/band indices
// and completed-frame counter, all advanced by compare-and-count only.
module vga_pattern_gen_cursor
    import vga_pattern_gen_pkg::*;
#(
    parameter int C_X         = 1920,
    parameter int C_Y         = 1080,
    parameter int C_BITS_X    = 11,
    parameter int C_BITS_Y    = 11,
    parameter int C_BARS      = 8,
    parameter int C_VSYNC_POL = 1
) (
    input  logic                clk_pixel,
    input  logic                rst,
    input  logic                fetch_next,
    input  logic                in_vsync,
    output logic                fs,
    output logic [C_BITS_X-1:0] x,
    output logic [C_BITS_Y-1:0] y,
    output logic [2:0]          bar,
    output logic [2:0]          band,
    output logic [7:0]          frame_count
);

    localparam int BW = C_X / C_BARS;
    localparam int BH = C_Y / C_BARS;
    localparam logic [C_BITS_X-1:0] X_LAST  = C_BITS_X'(C_X - 1);
    localparam logic [C_BITS_Y-1:0] Y_LAST  = C_BITS_Y'(C_Y - 1);
    localparam logic [C_BITS_X-1:0] BW_LAST = C_BITS_X'(BW - 1);
    localparam logic [C_BITS_Y-1:0] BH_LAST = C_BITS_Y'(BH - 1);
    localparam logic [C_BITS_X-1:0] X_ONE   = C_BITS_X'(1);
    localparam logic [C_BITS_Y-1:0] Y_ONE   = C_BITS_Y'(1);
    localparam logic [2:0]          IDX_MAX = 3'(C_BARS - 1);

    logic                vsync_act_s;
    logic                vsync_act_prev_r;
    logic [C_BITS_X-1:0] x_r;
    logic [C_BITS_Y-1:0] y_r;
    logic [C_BITS_X-1:0] bx_r;
    logic [C_BITS_Y-1:0] by_r;
    logic [2:0]          bar_r;
    logic [2:0]          band_r;
    logic [7:0]          frame_count_r;

    assign vsync_act_s = (C_VSYNC_POL != 0) ? in_vsync : ~in_vsync;
    assign fs          = vsync_act_s & ~vsync_act_prev_r;

    // Position counters; bx/by count pixels/lines within the current bar/band
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            vsync_act_prev_r <= 1'b0;
            x_r              <= '0;
            y_r              <= '0;
            bx_r             <= '0;
            by_r             <= '0;
            bar_r            <= 3'd0;
            band_r           <= 3'd0;
            frame_count_r    <= 8'd0;
        end else begin
            vsync_act_prev_r <= vsync_act_s;
            if (fs) begin
                x_r           <= '0;
                y_r           <= '0;
                bx_r          <= '0;
                by_r          <= '0;
                bar_r         <= 3'd0;
                band_r        <= 3'd0;
                frame_count_r <= frame_count_r + 8'd1;
            end else if (fetch_next) begin
                if (x_r == X_LAST) begin
                    x_r   <= '0;
                    bx_r  <= '0;
                    bar_r <= 3'd0;
                    if (y_r == Y_LAST) begin
                        y_r    <= '0;
                        by_r   <= '0;
                        band_r <= 3'd0;
                    end else begin
                        y_r <= y_r + Y_ONE;
                        if (by_r == BH_LAST) begin
                            by_r <= '0;
                            if (band_r != IDX_MAX) begin
                                band_r <= band_r + 3'd1;
                            end
                        end else begin
                            by_r <= by_r + Y_ONE;
                        end
                    end
                end else begin
                    x_r <= x_r + X_ONE;
                    if (bx_r == BW_LAST) begin
                        bx_r <= '0;
                        if (bar_r != IDX_MAX) begin
                            bar_r <= bar_r + 3'd1;
                        end
                    end else begin
                        bx_r <= bx_r + X_ONE;
                    end
                end
            end
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign bar         = bar_r;
    assign band        = band_r;
    assign frame_count = frame_count_r;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source between the VGA timing generator and the TMDS encoder;
// pattern state latches at frame start so a frame is never torn.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int C_X           = 1920,
    parameter int C_Y           = 1080,
    parameter int C_BITS_X      = 11,
    parameter int C_BITS_Y      = 11,
    parameter int C_BARS        = 8,
    parameter int C_CHECK_LOG2  = 5,
    parameter int C_HOLD_FRAMES = 30,
    parameter int C_VSYNC_POL   = 1
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic [2:0] solid_sel,
    input  logic       fetch_next,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic       in_blank,
    output logic [7:0] out_red,
    output logic [7:0] out_green,
    output logic [7:0] out_blue,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_blank,
    output logic [7:0] frame_count
);

    localparam int HOLD_W = (C_HOLD_FRAMES > 1) ? $clog2(C_HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(C_HOLD_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic VSYNC_IDLE = (C_VSYNC_POL != 0) ? 1'b0 : 1'b1;

    logic                fs_s;
    logic [C_BITS_X-1:0] x_s;
    logic [C_BITS_Y-1:0] y_s;
    logic [2:0]          bar_s;
    logic [2:0]          band_s;
    logic [7:0]          frame_count_s;

    mode_e               mode_r;
    logic [2:0]          solid_r;
    logic [HOLD_W-1:0]   hold_r;
    logic                alt_blue_r;
    rgb_t                pix_s;
    rgb_t                rgb_r;
    logic                hsync_r;
    logic                vsync_r;
    logic                blank_r;

    vga_pattern_gen_cursor #(
        .C_X         (C_X),
        .C_Y         (C_Y),
        .C_BITS_X    (C_BITS_X),
        .C_BITS_Y    (C_BITS_Y),
        .C_BARS      (C_BARS),
        .C_VSYNC_POL (C_VSYNC_POL)
    ) u_cursor (
        .clk_pixel   (clk_pixel),
        .rst         (rst),
        .fetch_next  (fetch_next),
        .in_vsync    (in_vsync),
        .fs          (fs_s),
        .x           (x_s),
        .y           (y_s),
        .bar         (bar_s),
        .band        (band_s),
        .frame_count (frame_count_s)
    );

    // Frame-start latch of mode/solid and the alternating-colour hold counter
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            mode_r     <= MODE_SOLID;
            solid_r    <= PAL_BLACK;
            hold_r     <= '0;
            alt_blue_r <= 1'b0;
        end else if (fs_s) begin
            mode_r  <= mode_e'(mode);
            solid_r <= solid_sel;
            if ((mode_e'(mode) != MODE_ALT) || (mode_r != MODE_ALT)) begin
                hold_r     <= '0;
                alt_blue_r <= 1'b0;
            end else if (hold_r == HOLD_LAST) begin
                hold_r     <= '0;
                alt_blue_r <= ~alt_blue_r;
            end else begin
                hold_r <= hold_r + HOLD_ONE;
            end
        end
    end

    // Pattern mux from the current (pre-advance) counters
    always_comb begin
        pix_s = palette(PAL_BLACK);
        case (mode_r)
            MODE_SOLID:   pix_s = palette(solid_r);
            MODE_VBARS:   pix_s = palette(bar_s);
            MODE_HBANDS:  pix_s = palette(band_s);
            MODE_CHECKER: begin
                if (x_s[C_CHECK_LOG2] ^ y_s[C_CHECK_LOG2]) begin
                    pix_s = palette(PAL_WHITE);
                end else begin
                    pix_s = palette(PAL_BLACK);
                end
            end
            MODE_GRADIENT: begin
                pix_s.red   = 8'(x_s);
                pix_s.green = 8'(y_s);
                pix_s.blue  = frame_count_s;
            end
            MODE_ALT: begin
                if (alt_blue_r) begin
                    pix_s = palette(PAL_BLUE);
                end else begin
                    pix_s = palette(PAL_RED);
                end
            end
            default: pix_s = palette(PAL_BLACK);
        endcase
    end

    // Output stage: one register for RGB and the re-timed syncs/blank
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            rgb_r   <= 24'h000000;
            hsync_r <= 1'b0;
            vsync_r <= VSYNC_IDLE;
            blank_r <= 1'b1;
        end else begin
            rgb_r   <= in_blank ? 24'h000000 : pix_s;
            hsync_r <= in_hsync;
            vsync_r <= in_vsync;
            blank_r <= in_blank;
        end
    end

    assign out_red     = rgb_r.red;
    assign out_green   = rgb_r.green;
    assign out_blue    = rgb_r.blue;
    assign out_hsync   = hsync_r;
    assign out_vsync   = vsync_r;
    assign out_blank   = blank_r;
    assign frame_count = frame_count_s;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench: two instances (4 bars / active-high vsync, 3 bars / active-low vsync)
// against a position-based reference model, plus literal pixel expectations.
module tb_vga_pattern_gen;

    localparam int XS = 16;
    localparam int YS = 8;

    logic       clk_pixel = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [2:0] solid_sel = 3'd0;
    logic       fetch_next = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       blank = 1'b1;
    logic       vsync_b;

    logic [7:0] a_r, a_g, a_b, a_fc, b_r, b_g, b_b, b_fc;
    logic       a_hs, a_vs, a_bl, b_hs, b_vs, b_bl;

    assign vsync_b = ~vsync;

    always #5 clk_pixel = ~clk_pixel;

    vga_pattern_gen #(.C_X(XS), .C_Y(YS), .C_BITS_X(5), .C_BITS_Y(4), .C_BARS(4),
        .C_CHECK_LOG2(1), .C_HOLD_FRAMES(2), .C_VSYNC_POL(1)) dut_a (
        .clk_pixel(clk_pixel), .rst(rst), .mode(mode), .solid_sel(solid_sel),
        .fetch_next(fetch_next), .in_hsync(hsync), .in_vsync(vsync), .in_blank(blank),
        .out_red(a_r), .out_green(a_g), .out_blue(a_b), .out_hsync(a_hs),
        .out_vsync(a_vs), .out_blank(a_bl), .frame_count(a_fc));

    vga_pattern_gen #(.C_X(XS), .C_Y(YS), .C_BITS_X(5), .C_BITS_Y(4), .C_BARS(3),
        .C_CHECK_LOG2(1), .C_HOLD_FRAMES(2), .C_VSYNC_POL(0)) dut_b (
        .clk_pixel(clk_pixel), .rst(rst), .mode(mode), .solid_sel(solid_sel),
        .fetch_next(fetch_next), .in_hsync(hsync), .in_vsync(vsync_b), .in_blank(blank),
        .out_red(b_r), .out_green(b_g), .out_blue(b_b), .out_hsync(b_hs),
        .out_vsync(b_vs), .out_blank(b_bl), .frame_count(b_fc));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_x, m_y, m_fc, m_mode, m_solid, m_altk;
    bit m_vprev;
    logic [23:0] e_rgb_a, e_rgb_b;
    logic        e_hs, e_vs_a, e_vs_b, e_bl;
    logic [7:0]  e_fc;
    logic [23:0] img_a [0:YS-1][0:XS-1];
    logic [23:0] img_b [0:YS-1][0:XS-1];

    function automatic logic [23:0] pal(input int idx);
        logic [23:0] t [0:7];
        t[0] = 24'h000000; t[1] = 24'hFF0000; t[2] = 24'h00FF00; t[3] = 24'h0000FF;
        t[4] = 24'hFFFF00; t[5] = 24'h00FFFF; t[6] = 24'hFF00FF; t[7] = 24'hFFFFFF;
        return t[idx & 7];
    endfunction

    function automatic logic [23:0] model_pix(input int bars);
        int bar, band;
        bar  = m_x / (XS / bars); if (bar > bars - 1) bar = bars - 1;
        band = m_y / (YS / bars); if (band > bars - 1) band = bars - 1;
        case (m_mode)
            0: return pal(m_solid);
            1: return pal(bar);
            2: return pal(band);
            3: return ((((m_x / 2) + (m_y / 2)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            4: return {8'(m_x), 8'(m_y), 8'(m_fc)};
            5: return (((m_altk / 2) % 2) == 0) ? 24'hFF0000 : 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply current inputs for one clock, advance the model, compare all outputs
    task automatic step();
        bit cap;
        int cx, cy;
        cap = !rst && !blank; cx = m_x; cy = m_y;
        if (rst) begin
            e_rgb_a = 24'h0; e_rgb_b = 24'h0; e_hs = 1'b0; e_vs_a = 1'b0; e_vs_b = 1'b1; e_bl = 1'b1;
            m_x = 0; m_y = 0; m_fc = 0; m_mode = 0; m_solid = 0; m_altk = 0; m_vprev = 1'b0;
        end else begin
            e_hs = hsync; e_vs_a = vsync; e_vs_b = ~vsync; e_bl = blank;
            e_rgb_a = blank ? 24'h0 : model_pix(4);
            e_rgb_b = blank ? 24'h0 : model_pix(3);
            if (vsync && !m_vprev) begin
                m_x = 0; m_y = 0; m_fc = (m_fc + 1) % 256;
                if (mode == 3'd5) m_altk = (m_mode == 5) ? m_altk + 1 : 0;
                m_mode = int'(mode); m_solid = int'(solid_sel);
            end else if (fetch_next) begin
                m_x++;
                if (m_x == XS) begin
                    m_x = 0; m_y++;
                    if (m_y == YS) m_y = 0;
                end
            end
            m_vprev = vsync;
        end
        e_fc = 8'(m_fc);
        @(posedge clk_pixel); #1;
        chk("rgb_a", {8'h0, a_r, a_g, a_b}, {8'h0, e_rgb_a});
        chk("rgb_b", {8'h0, b_r, b_g, b_b}, {8'h0, e_rgb_b});
        chk("sync_a", {29'h0, a_hs, a_vs, a_bl}, {29'h0, e_hs, e_vs_a, e_bl});
        chk("sync_b", {29'h0, b_hs, b_vs, b_bl}, {29'h0, e_hs, e_vs_b, e_bl});
        chk("fc_a", {24'h0, a_fc}, {24'h0, e_fc});
        chk("fc_b", {24'h0, b_fc}, {24'h0, e_fc});
        if (cap) begin
            img_a[cy][cx] = {a_r, a_g, a_b};
            img_b[cy][cx] = {b_r, b_g, b_b};
        end
    endtask

    // One timing-generator frame: vsync on line 1, active lines 3..10, 16 of 20 columns
    task automatic run_frame(input int md, input int sol, input int sw_line,
                             input int md2, input int sol2, input int rst_line);
        mode = 3'(md); solid_sel = 3'(sol);
        for (int vc = 0; vc < 11; vc++) begin
            for (int hc = 0; hc < 20; hc++) begin
                if (vc == sw_line && hc == 0) begin
                    mode = 3'(md2); solid_sel = 3'(sol2);
                end
                rst        = (vc == rst_line && hc == 6);
                vsync      = (vc == 1);
                hsync      = (hc == 17 || hc == 18);
                blank      = !(vc >= 3 && hc < 16);
                fetch_next = !blank;
                step();
                if (vc == rst_line && hc == 6) begin
                    chk("rst_mid_rgb", {8'h0, a_r, a_g, a_b}, 32'h0);
                    chk("rst_mid_blank", {31'h0, a_bl}, 32'h1);
                    chk("rst_mid_fc", {24'h0, a_fc}, 32'h0);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] alt_exp [0:5];
        logic [23:0] want;
        alt_exp[0] = 24'hFF0000; alt_exp[1] = 24'hFF0000; alt_exp[2] = 24'h0000FF;
        alt_exp[3] = 24'h0000FF; alt_exp[4] = 24'hFF0000; alt_exp[5] = 24'hFF0000;

        // Reset state
        rst = 1'b1; blank = 1'b0; fetch_next = 1'b1; vsync = 1'b1; hsync = 1'b1;
        step();
        chk("reset_rgb", {8'h0, a_r, a_g, a_b}, 32'h0);
        chk("reset_blank", {31'h0, a_bl}, 32'h1);
        chk("reset_hsync", {31'h0, a_hs}, 32'h0);
        chk("reset_vsync_a", {31'h0, a_vs}, 32'h0);
        chk("reset_vsync_b", {31'h0, b_vs}, 32'h1);
        chk("reset_fc", {24'h0, a_fc}, 32'h0);
        step();
        rst = 1'b0; vsync = 1'b0; blank = 1'b1; fetch_next = 1'b0; hsync = 1'b0;
        step();

        // Vertical bars: 4-pixel bars black/red/green/blue on every line
        run_frame(1, 0, -1, 0, 0, -1);
        for (int y = 0; y < YS; y += 5) begin
            for (int x = 0; x < XS; x++) begin
                want = (x < 4) ? 24'h000000 : (x < 8) ? 24'hFF0000 : (x < 12) ? 24'h00FF00 : 24'h0000FF;
                chk("vbars", {8'h0, img_a[y][x]}, {8'h0, want});
            end
        end

        // Horizontal bands: 3 bands of 2 lines, last band absorbs remainder
        run_frame(2, 0, -1, 0, 0, -1);
        for (int y = 0; y < YS; y++) begin
            want = (y < 2) ? 24'h000000 : (y < 4) ? 24'hFF0000 : 24'h00FF00;
            chk("hbands3", {8'h0, img_b[y][7]}, {8'h0, want});
        end
        chk("hbands4_last", {8'h0, img_a[7][3]}, 32'h0000FF);

        // Checkerboard with 2-pixel squares
        run_frame(3, 0, -1, 0, 0, -1);
        chk("check_2_0", {8'h0, img_a[0][2]}, 32'hFFFFFF);
        chk("check_0_0", {8'h0, img_a[0][0]}, 32'h000000);
        chk("check_2_2", {8'h0, img_a[2][2]}, 32'h000000);

        // Alternating colour, then a mid-frame switch that must not tear
        for (int f = 0; f < 6; f++) begin
            run_frame(5, 0, (f == 5) ? 6 : -1, 0, 6, -1);
            chk("alt_first", {8'h0, img_a[0][0]}, {8'h0, alt_exp[f]});
            chk("alt_last", {8'h0, img_a[7][15]}, {8'h0, alt_exp[f]});
        end
        run_frame(0, 6, -1, 0, 0, -1);
        chk("solid_after_switch", {8'h0, img_a[3][5]}, 32'hFF00FF);

        // Frame start coincident with fetch_next
        mode = 3'd1; blank = 1'b0; hsync = 1'b0; vsync = 1'b0; fetch_next = 1'b1;
        for (int i = 0; i < 6; i++) step();
        vsync = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("fs_fetch_px0", {8'h0, img_a[0][0]}, 32'h000000);
        chk("fs_fetch_px4", {8'h0, img_a[0][4]}, 32'hFF0000);
        vsync = 1'b0; blank = 1'b1; fetch_next = 1'b0;
        step();

        // Reset mid-line, pattern recovers from the next frame start
        run_frame(1, 0, -1, 0, 0, 5);
        run_frame(1, 0, -1, 0, 0, -1);
        chk("post_rst_px", {8'h0, img_a[2][4]}, 32'hFF0000);
        chk("post_rst_px0", {8'h0, img_a[2][0]}, 32'h000000);
        chk("post_rst_fc", {24'h0, a_fc}, 32'h1);

        // Gradient
        run_frame(4, 0, -1, 0, 0, -1);
        chk("gradient_rg", {16'h0, img_a[3][5][23:8]}, 32'h0503);

        // Randomised inputs, including sync edges coinciding with fetches
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            fetch_next = $urandom_range(0, 1) == 1;
            blank      = $urandom_range(0, 3) == 0;
            hsync      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 39) == 0) vsync = ~vsync;
            if ($urandom_range(0, 49) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) solid_sel = 3'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(3, 10), $urandom_range(0, 7), $urandom_range(0, 7), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
